// File: rtl/alu_result_disp.sv
// Result display for the 4-bit switch ALU: captures one result per handshake,
// holds it for HOLD cycles and shows it on a scanned 4-digit seven-segment display.
module alu_result_disp #(
  parameter int SCAN_W  = 10,
  parameter int BLINK_W = 22,
  parameter int HOLD    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       res_valid,
  output logic       res_ready,
  input  logic [2:0] res_func,
  input  logic [3:0] res_val,
  input  logic       res_cout,
  input  logic       res_ovf,
  input  logic       res_zero,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic [2:0] led_flags
);

  localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD - 1);

  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_C     = 8'hC6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_SHOW = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [1:0]          dig_idx_q, dig_idx_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic [2:0]          cap_func_q, cap_func_d;
  logic [3:0]          cap_val_q, cap_val_d;
  logic                cap_cout_q, cap_cout_d;
  logic                cap_ovf_q, cap_ovf_d;
  logic                cap_zero_q, cap_zero_d;

  logic                accept;
  logic                neg;
  logic [3:0]          mag;
  logic [7:0]          dig_code;

  function automatic logic [7:0] hex_seg(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  assign res_ready = (state_q != S_HOLD);
  assign accept    = res_valid & res_ready;

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    scan_cnt_d  = scan_cnt_q + SCAN_W'(1);
    dig_idx_d   = dig_idx_q;
    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    cap_func_d  = cap_func_q;
    cap_val_d   = cap_val_q;
    cap_cout_d  = cap_cout_q;
    cap_ovf_d   = cap_ovf_q;
    cap_zero_d  = cap_zero_q;

    if (&scan_cnt_q) begin
      dig_idx_d = dig_idx_q + 2'd1;
    end

    case (state_q)
      S_HOLD: begin
        if (hold_cnt_q == '0) begin
          state_d = S_SHOW;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      default: begin
        if (accept) begin
          state_d    = S_HOLD;
          hold_cnt_d = HOLD_LOAD;
          cap_func_d = res_func;
          cap_val_d  = res_val;
          cap_cout_d = res_cout;
          cap_ovf_d  = res_ovf;
          cap_zero_d = res_zero;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hold_cnt_q  <= '0;
      scan_cnt_q  <= '0;
      dig_idx_q   <= '0;
      blink_cnt_q <= '0;
      cap_func_q  <= '0;
      cap_val_q   <= '0;
      cap_cout_q  <= 1'b0;
      cap_ovf_q   <= 1'b0;
      cap_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      scan_cnt_q  <= scan_cnt_d;
      dig_idx_q   <= dig_idx_d;
      blink_cnt_q <= blink_cnt_d;
      cap_func_q  <= cap_func_d;
      cap_val_q   <= cap_val_d;
      cap_cout_q  <= cap_cout_d;
      cap_ovf_q   <= cap_ovf_d;
      cap_zero_q  <= cap_zero_d;
    end
  end

  // Only add/sub results are treated as two's complement; 1000 shows as -8.
  always_comb begin
    neg = 1'b0;
    mag = cap_val_q;
    if (cap_func_q[2:1] == 2'b00 && cap_val_q[3]) begin
      neg = 1'b1;
      mag = ~cap_val_q + 4'd1;
    end
  end

  always_comb begin
    dig_code = SEG_BLANK;
    case (dig_idx_q)
      2'd0: dig_code = hex_seg(mag);
      2'd1: dig_code = neg ? SEG_DASH : SEG_BLANK;
      2'd2: dig_code = hex_seg({1'b0, cap_func_q});
      default: begin
        if (cap_ovf_q)       dig_code = SEG_E;
        else if (cap_cout_q) dig_code = SEG_C;
        else                 dig_code = SEG_BLANK;
      end
    endcase

    if (state_q == S_IDLE) begin
      dig_code = SEG_DASH;
    end else if (state_q == S_SHOW && cap_ovf_q && blink_cnt_q[BLINK_W-1]) begin
      dig_code = SEG_BLANK;
    end
  end

  assign seg = {1'b1, dig_code[6:0]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_an
    assign an[gi] = (dig_idx_q != 2'(gi));
  end

  assign led_flags = {cap_zero_q, cap_ovf_q, cap_cout_q};

endmodule

// File: tb/tb_alu_result_disp.sv
// Directed bench for alu_result_disp with SCAN_W=2, BLINK_W=4, HOLD=4.
module tb_alu_result_disp;

  logic       clk;
  logic       rst;
  logic       res_valid;
  logic       res_ready;
  logic [2:0] res_func;
  logic [3:0] res_val;
  logic       res_cout;
  logic       res_ovf;
  logic       res_zero;
  logic [7:0] seg;
  logic [3:0] an;
  logic [2:0] led_flags;

  int pass_cnt;
  int total_cnt;
  logic [7:0] digs [4];

  alu_result_disp #(
    .SCAN_W (2),
    .BLINK_W(4),
    .HOLD   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_func (res_func),
    .res_val  (res_val),
    .res_cout (res_cout),
    .res_ovf  (res_ovf),
    .res_zero (res_zero),
    .seg      (seg),
    .an       (an),
    .led_flags(led_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one handshake from a negedge; returns at the negedge of the first HOLD cycle.
  task automatic send(input logic [2:0] f, input logic [3:0] v,
                      input logic c, input logic o, input logic z);
    res_func  = f;
    res_val   = v;
    res_cout  = c;
    res_ovf   = o;
    res_zero  = z;
    res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!res_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  // One full scan; records each digit's segments when they are not blanked.
  task automatic scan_digits(output int ff_cnt);
    ff_cnt = 0;
    for (int i = 0; i < 4; i++) digs[i] = 8'h00;
    for (int i = 0; i < 16; i++) begin
      if (seg == 8'hFF) ff_cnt++;
      case (an)
        4'b1110: if (seg != 8'hFF || digs[0] == 8'h00) digs[0] = seg;
        4'b1101: if (seg != 8'hFF || digs[1] == 8'h00) digs[1] = seg;
        4'b1011: if (seg != 8'hFF || digs[2] == 8'h00) digs[2] = seg;
        4'b0111: if (seg != 8'hFF || digs[3] == 8'h00) digs[3] = seg;
        default: ;
      endcase
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int ff;
    rst = 1'b1;
    res_valid = 1'b0;
    res_func = '0; res_val = '0; res_cout = 0; res_ovf = 0; res_zero = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if ({an, seg, res_ready, led_flags} !== {4'b1110, 8'hBF, 1'b1, 3'b000})
      $display("FAIL reset_state: an=%b seg=%h ready=%b led=%b, need an=1110 seg=bf ready=1 led=000",
               an, seg, res_ready, led_flags);
    else pass_cnt++;
    repeat (4) @(negedge clk);
    total_cnt++;
    if (an !== 4'b1101) $display("FAIL reset_scan_step: an=%b need 1101", an);
    else pass_cnt++;
    scan_digits(ff);
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (digs[i] !== 8'hBF) $display("FAIL idle_dig%0d: seg=%h need bf", i, digs[i]);
      else pass_cnt++;
    end
    $display("reset: idle scan done");
  endtask

  task automatic test_add_pos();
    int n, ff;
    send(3'b000, 4'b0110, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (res_ready !== 1'b0) $display("FAIL hold_ready_c%0d: ready=%b need 0", i, res_ready);
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++;
    if (res_ready !== 1'b1) $display("FAIL hold_release: ready=%b need 1", res_ready);
    else pass_cnt++;
    scan_digits(ff);
    total_cnt++;
    if ({digs[0], digs[1], digs[2], digs[3]} !== {8'h82, 8'hFF, 8'hC0, 8'hFF})
      $display("FAIL add_pos_digits: got %h %h %h %h need 82 ff c0 ff", digs[0], digs[1], digs[2], digs[3]);
    else pass_cnt++;
    $display("add_pos: func=000 val=0110 captured");
  endtask

  task automatic test_sub_neg();
    int n, ff;
    send(3'b001, 4'b1101, 1'b1, 1'b0, 1'b0);
    wait_ready(n);
    total_cnt++;
    if (n != 4) $display("FAIL sub_hold_len: waited %0d need 4", n);
    else pass_cnt++;
    scan_digits(ff);
    total_cnt++;
    if ({digs[0], digs[1], digs[2], digs[3]} !== {8'hB0, 8'hBF, 8'hF9, 8'hC6})
      $display("FAIL sub_neg_digits: got %h %h %h %h need b0 bf f9 c6", digs[0], digs[1], digs[2], digs[3]);
    else pass_cnt++;
    total_cnt++;
    if (led_flags !== 3'b001) $display("FAIL sub_leds: led=%b need 001", led_flags);
    else pass_cnt++;
    $display("sub_neg: func=001 val=1101 cout=1 captured");
  endtask

  task automatic test_ovf_blink();
    int n, ff, k;
    // Time the handshake so the four HOLD cycles all scan digit 3 (no blink in HOLD).
    k = 0;
    while (an == 4'b1011 && k < 20) begin @(negedge clk); k++; end
    while (an != 4'b1011 && k < 40) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    send(3'b000, 4'b1000, 1'b0, 1'b1, 1'b0);
    total_cnt++;
    if (an !== 4'b0111 || seg !== 8'h86)
      $display("FAIL ovf_dig3: an=%b seg=%h need an=0111 seg=86", an, seg);
    else pass_cnt++;
    total_cnt++;
    if (led_flags !== 3'b010) $display("FAIL ovf_leds: led=%b need 010", led_flags);
    else pass_cnt++;
    wait_ready(n);
    scan_digits(ff);
    total_cnt++;
    if (ff != 8) $display("FAIL ovf_blink_count: blank cycles=%0d need 8", ff);
    else pass_cnt++;
    total_cnt++;
    if ({digs[0], digs[1]} !== {8'h80, 8'hBF})
      $display("FAIL ovf_digits: got %h %h need 80 bf", digs[0], digs[1]);
    else pass_cnt++;
    total_cnt++;
    if (led_flags !== 3'b010) $display("FAIL ovf_leds_steady: led=%b need 010", led_flags);
    else pass_cnt++;
    $display("ovf_blink: func=000 val=1000 ovf=1 blank=%0d", ff);
  endtask

  task automatic test_back_to_back();
    int n, ff;
    logic changed;
    send(3'b010, 4'b0001, 1'b1, 1'b0, 1'b0);
    res_func = 3'b011; res_val = 4'b1010; res_cout = 0; res_ovf = 0; res_zero = 0;
    res_valid = 1'b1;
    n = 0;
    changed = 1'b0;
    while (!res_ready && n < 20) begin
      if (led_flags !== 3'b001) changed = 1'b1;
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (changed || n != 4) $display("FAIL hold_ignore: changed=%b waited=%0d need 0/4", changed, n);
    else pass_cnt++;
    @(negedge clk);
    res_valid = 1'b0;
    total_cnt++;
    if ({led_flags, res_ready} !== {3'b000, 1'b0})
      $display("FAIL late_capture: led=%b ready=%b need 000/0", led_flags, res_ready);
    else pass_cnt++;
    wait_ready(n);
    scan_digits(ff);
    total_cnt++;
    if ({digs[0], digs[1], digs[2], digs[3]} !== {8'h88, 8'hFF, 8'hB0, 8'hFF})
      $display("FAIL unsigned_digits: got %h %h %h %h need 88 ff b0 ff", digs[0], digs[1], digs[2], digs[3]);
    else pass_cnt++;
    $display("back_to_back: func=011 val=1010 captured after hold");
  endtask

  task automatic test_reset_mid_hold();
    int n, ff;
    send(3'b001, 4'b0001, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if ({res_ready, seg, led_flags, an} !== {1'b1, 8'hBF, 3'b000, 4'b1110})
      $display("FAIL rst_mid_hold: ready=%b seg=%h led=%b an=%b need 1/bf/000/1110",
               res_ready, seg, led_flags, an);
    else pass_cnt++;
    send(3'b111, 4'b0000, 1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (led_flags !== 3'b100) $display("FAIL zero_leds: led=%b need 100", led_flags);
    else pass_cnt++;
    wait_ready(n);
    scan_digits(ff);
    total_cnt++;
    if ({digs[0], digs[1], digs[2], digs[3]} !== {8'hC0, 8'hFF, 8'hF8, 8'hFF})
      $display("FAIL zero_digits: got %h %h %h %h need c0 ff f8 ff", digs[0], digs[1], digs[2], digs[3]);
    else pass_cnt++;
    $display("reset_mid_hold: func=111 zero=1 captured after reset");
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst = 1'b1;
    res_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_add_pos();
    test_sub_neg();
    test_ovf_blink();
    test_back_to_back();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
